// File: rtl/key_schedule.sv
// AES-128 on-the-fly key expansion: emits round keys 0..NUM_ROUNDS one per
// accepted valid/ready transfer, holding only the current round key.
module key_schedule #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         key_ready,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         key_valid,
  output logic         busy,
  output logic         done
);

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  // Forward S-box, entry 0 at the most significant end.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h000000};
    n0 = k[127:96] ^ t;
    n1 = k[95:64]  ^ n0;
    n2 = k[63:32]  ^ n1;
    n3 = k[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  state_t       r_state, w_state_nxt;
  logic [127:0] r_key, w_key_nxt;
  logic [3:0]   r_idx, w_idx_nxt;
  logic         r_valid, w_valid_nxt;
  logic         r_done, w_done_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_key_nxt   = r_key;
    w_idx_nxt   = r_idx;
    w_valid_nxt = r_valid;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_key_nxt   = key_in;
          w_idx_nxt   = 4'd0;
          w_valid_nxt = 1'b1;
          w_state_nxt = S_EMIT;
        end
      end
      S_EMIT: begin
        if (r_valid && key_ready) begin
          if (r_idx == LAST_IDX) begin
            w_valid_nxt = 1'b0;
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_key_nxt = expand(r_key, rcon(r_idx));
            w_idx_nxt = r_idx + 4'd1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_key   <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_key   <= w_key_nxt;
      r_idx   <= w_idx_nxt;
      r_valid <= w_valid_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign round_key = r_key;
  assign round_idx = r_idx;
  assign key_valid = r_valid;
  assign busy      = (r_state == S_EMIT);
  assign done      = r_done;

endmodule

// File: tb/tb_key_schedule.sv
// Bench for key_schedule: a word-level FIPS-197 expansion model (S-box derived
// from the GF(2^8) inverse) checked every cycle, plus directed literal vectors.
module tb_key_schedule;

  typedef logic [0:10][127:0] ks_t;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam int           NR       = 10;

  logic         clk = 1'b0;
  logic         rst, start, key_ready;
  logic [127:0] key_in;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         key_valid, busy, done;

  logic         rst2, start2, key_ready2;
  logic [127:0] key_in2;
  logic [127:0] round_key2;
  logic [3:0]   round_idx2;
  logic         key_valid2, busy2, done2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] tb_sbox [256];

  bit   m_armed  = 1'b0;
  bit   m_active = 1'b0;
  bit   m_done   = 1'b0;
  int   m_idx    = 0;
  ks_t  m_ks;

  always #5 clk = ~clk;

  key_schedule #(.NUM_ROUNDS(NR)) dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .key_ready(key_ready),
    .round_key(round_key), .round_idx(round_idx), .key_valid(key_valid),
    .busy(busy), .done(done)
  );

  key_schedule #(.NUM_ROUNDS(2)) dut2 (
    .clk(clk), .rst(rst2), .start(start2), .key_in(key_in2), .key_ready(key_ready2),
    .round_key(round_key2), .round_idx(round_idx2), .key_valid(key_valid2),
    .busy(busy2), .done(done2)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [31:0] tb_subw(input logic [31:0] w);
    return {tb_sbox[w[31:24]], tb_sbox[w[23:16]], tb_sbox[w[15:8]], tb_sbox[w[7:0]]};
  endfunction

  // Textbook word expansion: w[i] = w[i-4] ^ temp, over 44 words.
  function automatic ks_t fips_expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] temp;
    logic [7:0]  rc;
    ks_t         ks;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        rc = 8'h01;
        for (int j = 1; j < i / 4; j++) rc = gmul(rc, 8'h02);
        temp = tb_subw({temp[23:0], temp[31:24]}) ^ {rc, 24'h000000};
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r <= 10; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return ks;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_loop();
    forever begin
      @(posedge clk);
      if (rst) begin
        m_armed = 1'b1; m_active = 1'b0; m_done = 1'b0; m_idx = 0;
      end else begin
        m_done = 1'b0;
        if (!m_active) begin
          if (start) begin
            m_ks = fips_expand(key_in); m_active = 1'b1; m_idx = 0;
          end
        end else if (key_ready) begin
          if (m_idx == NR) begin
            m_active = 1'b0; m_done = 1'b1;
          end else begin
            m_idx++;
          end
        end
      end
      @(negedge clk);
      if (m_armed) begin
        chk("model key_valid", 128'(key_valid), 128'(m_active));
        chk("model busy", 128'(busy), 128'(m_active));
        chk("model done", 128'(done), 128'(m_done));
        if (m_active) begin
          chk("model round_idx", 128'(round_idx), 128'(m_idx));
          chk("model round_key", round_key, m_ks[m_idx]);
        end
      end
    end
  endtask

  task automatic run_start(input logic [127:0] k);
    @(negedge clk);
    start = 1'b1; key_in = k;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idx(input logic [3:0] t);
    int n = 0;
    while (!(key_valid === 1'b1 && round_idx === t) && n < 40) begin
      @(negedge clk); n++;
    end
    chk("wait_idx bound", 128'(n < 40), 128'(1));
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk); n++;
    end
    chk("wait_done bound", 128'(n < 40), 128'(1));
  endtask

  initial begin
    int          nvalid;
    int          ndone;
    logic [127:0] k10, nk;
    ks_t          ks_pin;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] b;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      tb_sbox[x] = b;
    end
    chk("pin sbox[00]", 128'(tb_sbox[0]), 128'(8'h63));
    chk("pin sbox[53]", 128'(tb_sbox[8'h53]), 128'(8'hed));
    ks_pin = fips_expand(FIPS_KEY);
    chk("pin model idx1", ks_pin[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("pin model idx10", ks_pin[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    rst = 1'b1; start = 1'b0; key_ready = 1'b0; key_in = '0;
    rst2 = 1'b1; start2 = 1'b0; key_ready2 = 1'b0; key_in2 = '0;
    fork model_loop(); join_none
    repeat (3) @(negedge clk);
    chk("reset key_valid", 128'(key_valid), 128'(0));
    chk("reset busy", 128'(busy), 128'(0));
    chk("reset done", 128'(done), 128'(0));
    chk("reset round_key", round_key, 128'(0));
    chk("reset round_idx", 128'(round_idx), 128'(0));
    rst = 1'b0;

    // FIPS-197 vector with key_ready held high.
    key_ready = 1'b1;
    run_start(FIPS_KEY);
    chk("fips idx0", round_key, FIPS_KEY);
    nvalid = 1; ndone = 0; k10 = '0;
    for (int c = 0; c < 20 && ndone == 0; c++) begin
      @(negedge clk);
      if (key_valid && round_idx == 4'd1) chk("fips idx1", round_key, 128'ha0fafe1788542cb123a339392a6c7605);
      if (key_valid && round_idx == 4'd10) k10 = round_key;
      if (key_valid) nvalid++;
      if (done) ndone++;
    end
    chk("fips idx10", k10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("fips valid cycles", 128'(nvalid), 128'(11));
    chk("fips done seen", 128'(ndone), 128'(1));
    @(negedge clk);
    chk("done one cycle", 128'(done), 128'(0));

    // Stall at round 3 for five cycles.
    run_start(FIPS_KEY);
    wait_idx(4'd3);
    key_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stall idx", 128'(round_idx), 128'(3));
      chk("stall key", round_key, 128'h3d80477d4716fe3e1e237e446d7a883b);
    end
    key_ready = 1'b1;
    @(negedge clk);
    chk("resume idx4", round_key, 128'hef44a541a8525b7fb671253bdb0bad00);
    wait_done();

    // start while busy is ignored.
    run_start(FIPS_KEY);
    wait_idx(4'd5);
    start = 1'b1; key_in = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    start = 1'b0;
    wait_idx(4'd10);
    chk("busy-start idx10", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    wait_done();

    // Reset in the middle of an expansion.
    run_start(FIPS_KEY);
    wait_idx(4'd6);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort key_valid", 128'(key_valid), 128'(0));
    chk("abort busy", 128'(busy), 128'(0));
    chk("abort round_key", round_key, 128'(0));
    chk("abort done", 128'(done), 128'(0));
    run_start(128'h0);
    @(negedge clk);
    chk("zero key idx1", round_key, 128'h62636363626363636263636362636363);

    // Back-to-back: start on the done cycle.
    wait_done();
    nk = {$urandom, $urandom, $urandom, $urandom};
    start = 1'b1; key_in = nk;
    @(negedge clk);
    start = 1'b0;
    chk("b2b key_valid", 128'(key_valid), 128'(1));
    chk("b2b round_idx", 128'(round_idx), 128'(0));
    chk("b2b round_key", round_key, nk);

    // Randomised traffic: stalls, spurious starts, occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      key_ready = ($urandom_range(0, 3) != 0);
      start     = ($urandom_range(0, 4) == 0);
      key_in    = {$urandom, $urandom, $urandom, $urandom};
      rst       = ($urandom_range(0, 149) == 0);
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0; key_ready = 1'b1;
    repeat (15) @(negedge clk);

    // NUM_ROUNDS = 2 instance.
    @(negedge clk);
    rst2 = 1'b0; start2 = 1'b1; key_in2 = FIPS_KEY; key_ready2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    chk("nr2 idx0 valid", 128'(key_valid2), 128'(1));
    chk("nr2 idx0 key", round_key2, FIPS_KEY);
    @(negedge clk);
    chk("nr2 idx1 key", round_key2, 128'ha0fafe1788542cb123a339392a6c7605);
    @(negedge clk);
    chk("nr2 idx2 idx", 128'(round_idx2), 128'(2));
    chk("nr2 idx2 key", round_key2, 128'hf2c295f27a96b9435935807a7359f67f);
    @(negedge clk);
    chk("nr2 done", 128'(done2), 128'(1));
    chk("nr2 valid low", 128'(key_valid2), 128'(0));
    @(negedge clk);
    chk("nr2 done cleared", 128'(done2), 128'(0));
    chk("nr2 busy", 128'(busy2), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
